// File: rtl/snow64_instr_fetch.sv
// snow64_instr_fetch: fetch stage that issues one request at a time to the instruction cache and buffers hits for decode.
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   out_icache_req, out_icache_addr  read request and byte address to the cache
//   in_icache_valid, in_icache_instr hit and instruction for the request captured on the previous edge
//   in_redirect, in_redirect_pc      flush the buffer and restart fetch at a new PC
//   out_instr_valid/out_instr/out_instr_pc, in_instr_ready  head of the instruction buffer, valid/ready handshake
// Optional: define SNOW64_INSTR_FETCH_PERF_COUNTERS_EN to add out_perf_fetched and out_perf_reissues.
module snow64_instr_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        out_icache_req,
    output logic [63:0] out_icache_addr,
    input  logic        in_icache_valid,
    input  logic [31:0] in_icache_instr,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc,
    output logic        out_instr_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_instr_pc,
    input  logic        in_instr_ready
`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] out_perf_fetched,
    output logic [31:0] out_perf_reissues
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];

    typedef enum logic {StIssue, StCheck} state_t;

    state_t        state, state_next;
    logic [63:0]   pc;
    logic [31:0]   mem_instr [FIFO_DEPTH];
    logic [63:0]   mem_pc    [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          not_full, push, pop;

    assign not_full        = count < FULL;
    assign out_icache_addr = pc;
    assign out_instr_valid = count != '0;
    assign out_instr       = mem_instr[rd_ptr];
    assign out_instr_pc    = mem_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= StIssue;
        else        state <= state_next;

    // The request is held low while reset is asserted even though the FSM already sits in StIssue.
    always_comb begin
        state_next     = in_redirect ? StIssue : (state == StIssue && not_full) ? StCheck : StIssue;
        out_icache_req = rst_n && state == StIssue && not_full;
        push           = state == StCheck && in_icache_valid && !in_redirect;
        pop            = out_instr_valid && in_instr_ready && !in_redirect;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (in_redirect) begin
            pc     <= in_redirect_pc & ~64'h3;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= in_icache_instr;
                mem_pc[wr_ptr]    <= pc;
                wr_ptr            <= wr_ptr + 1'b1;
                pc                <= pc + 64'd4;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_perf_fetched  <= '0;
            out_perf_reissues <= '0;
        end else begin
            if (push) out_perf_fetched <= out_perf_fetched + 32'd1;
            if (state == StCheck && !in_icache_valid) out_perf_reissues <= out_perf_reissues + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_snow64_instr_fetch.sv
// tb_snow64_instr_fetch: randomized scoreboard bench for snow64_instr_fetch against a queue-based fetch model.
module tb_snow64_instr_fetch;
    localparam int          DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        out_icache_req, in_icache_valid = 1'b0, in_redirect = 1'b0, in_instr_ready = 1'b0;
    logic        out_instr_valid;
    logic [63:0] out_icache_addr, in_redirect_pc = '0, out_instr_pc;
    logic [31:0] in_icache_instr = '0, out_instr;
`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
    logic [31:0] out_perf_fetched, out_perf_reissues;
`endif

    always #5 clk = ~clk;

    snow64_instr_fetch #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .out_icache_req(out_icache_req), .out_icache_addr(out_icache_addr),
        .in_icache_valid(in_icache_valid), .in_icache_instr(in_icache_instr),
        .in_redirect(in_redirect), .in_redirect_pc(in_redirect_pc),
        .out_instr_valid(out_instr_valid), .out_instr(out_instr), .out_instr_pc(out_instr_pc),
        .in_instr_ready(in_instr_ready)
`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
        , .out_perf_fetched(out_perf_fetched), .out_perf_reissues(out_perf_reissues)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    int          checks = 0, errors = 0, pops = 0, pushes = 0;
    ent_t        q[$];
    ent_t        e;
    logic [63:0] mpc = RPC;
    logic [63:0] pend_addr = '0;
    logic        pend = 1'b0, stale = 1'b0;
    logic        p_req = 1'b0, p_red = 1'b0, pp_req = 1'b0, pp_red = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard: the queue holds what the buffer must contain; the fetch PC advances only on accepted hits.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_vs_occupancy", out_instr_valid, q.size() != 0);
            if (q.size() == DEPTH) chk("req_when_full", out_icache_req, 1'b0);
            if (out_icache_req) chk("req_addr", out_icache_addr, mpc);
            if (p_req && !p_red) chk("req_back_to_back", out_icache_req, 1'b0);
            if (p_red) chk("req_after_redirect", out_icache_req, 1'b1);
            else if (pp_req && !pp_red && q.size() < DEPTH) chk("reissue_cadence", out_icache_req, 1'b1);
            if (in_redirect) begin
                q.delete();
                mpc = in_redirect_pc & ~64'h3;
            end else begin
                if (out_instr_valid && in_instr_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("instr", out_instr, e.instr);
                    chk("instr_pc", out_instr_pc, e.pc);
                    pops++;
                end
                // a response to a request made during a redirect cycle is stale and must be dropped
                if (in_icache_valid && !stale) begin
                    q.push_back('{instr: mpc[31:0] ^ 32'hA5A5A5A5, pc: mpc});
                    mpc += 64'd4;
                    pushes++;
                end
            end
            stale     = out_icache_req && in_redirect;
            pp_req    = p_req;
            pp_red    = p_red;
            p_req     = out_icache_req;
            p_red     = in_redirect;
            pend      = out_icache_req;
            pend_addr = out_icache_addr;
        end
    end

    task automatic cyc(input int hitp, input int rdyp, input int redp);
        @(posedge clk);
        #1;
        in_icache_valid = pend && ($urandom_range(99) < hitp);
        in_icache_instr = in_icache_valid ? pend_addr[31:0] ^ 32'hA5A5A5A5 : $urandom;
        in_instr_ready  = $urandom_range(99) < rdyp;
        in_redirect     = $urandom_range(99) < redp;
        in_redirect_pc  = ($urandom_range(3) == 0) ? {60'hFFFFFFFFFFFFFFF, 4'($urandom)} : {48'h0, 16'($urandom)};
    endtask

    task automatic redir(input logic [63:0] target);
        @(posedge clk);
        #1;
        in_icache_valid = pend;
        in_icache_instr = pend_addr[31:0] ^ 32'hA5A5A5A5;
        in_redirect     = 1'b1;
        in_redirect_pc  = target;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n           = 1'b0;
        in_icache_valid = 1'b0;
        in_redirect     = 1'b0;
        #1;
        chk("rst_req", out_icache_req, 1'b0);
        chk("rst_addr", out_icache_addr, RPC);
        chk("rst_valid", out_instr_valid, 1'b0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_instr_pc", out_instr_pc, 64'h0);
`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
        chk("rst_perf_fetched", out_perf_fetched, 32'h0);
        chk("rst_perf_reissues", out_perf_reissues, 32'h0);
`endif
        q.delete();
        mpc    = RPC;
        pend   = 1'b0;
        stale  = 1'b0;
        p_req  = 1'b0;
        p_red  = 1'b0;
        pp_req = 1'b0;
        pp_red = 1'b0;
        pushes = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        repeat (20) cyc(100, 100, 0);
        redir(64'h40);
        repeat (6) cyc(0, 100, 0);
        repeat (10) cyc(100, 100, 0);
        redir(64'h0);
        repeat (20) cyc(100, 0, 0);
        chk("bp_head_pc", out_instr_pc, 64'h0);
        chk("bp_no_req", out_icache_req, 1'b0);
        repeat (20) cyc(100, 100, 0);
        redir(64'h1003);
        repeat (4) cyc(100, 100, 0);
        for (int i = 0; i < 30; i++) repeat (100) cyc($urandom_range(20, 100), $urandom_range(10, 100), $urandom_range(0, 6));
        repeat (3) cyc(0, 50, 0);
        do_reset();
        repeat (500) cyc(80, 70, 3);
        chk("progress", pops > 200, 1'b1);
`ifdef SNOW64_INSTR_FETCH_PERF_COUNTERS_EN
        @(negedge clk);
        #1;
        chk("perf_fetched", out_perf_fetched, 64'(pushes));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snow64_instr_fetch.md
# snow64_instr_fetch

Instruction fetch stage sitting directly upstream of the Snow64 instruction cache. It owns the fetch PC, issues one read request at a time to the cache, and re-issues the request after a miss until it hits. Returned instructions are buffered in a small FIFO and handed to decode over a valid/ready handshake. A redirect input flushes the buffer and restarts fetch at a new PC.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: instruction buffer entries; must be a power of two and at least 2.
- `RESET_PC`, default 64'h0: fetch PC loaded at reset; must be 4-byte aligned.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `out_icache_req`, output, 1: read request to the cache.
- `out_icache_addr`, output, 64: effective byte address of the request.
- `in_icache_valid`, input, 1: the cache hit for the request captured on the previous edge.
- `in_icache_instr`, input, 32: instruction for that hit.
- `in_redirect`, input, 1: flush the FIFO and restart fetch.
- `in_redirect_pc`, input, 64: new fetch PC; bits [1:0] are ignored and treated as 0.
- `out_instr_valid`, output, 1: the FIFO head is valid.
- `out_instr`, output, 32: FIFO head instruction.
- `out_instr_pc`, output, 64: FIFO head PC.
- `in_instr_ready`, input, 1: decode accepts the head.

## Operation
- Registered state: `pc` (next address to fetch), a FIFO of {instr, pc} entries, an occupancy count of width log2(FIFO_DEPTH)+1, and `state` ∈ {StIssue, StCheck}.
- **StIssue**
  - If count < FIFO_DEPTH: drive `out_icache_req`=1 and `out_icache_addr`=`pc`, then go to StCheck.
  - Otherwise drive `out_icache_req`=0 and stay in StIssue.
- **StCheck**
  - Drive `out_icache_req`=0.
  - If `in_icache_valid`=1: push {`in_icache_instr`, `pc`}, set `pc` to `pc`+4 (64-bit wrap), go to StIssue.
  - Otherwise (miss, or the cache is busy filling): leave `pc` unchanged and go to StIssue to re-issue.
  - The cache drops a captured request after a fill, so re-issuing is mandatory. Re-issues made while the cache is filling are ignored by the cache and are harmless.
- **Issue gating.** The gate on count guarantees a push in StCheck never overflows the FIFO.
- **Dequeue.**
  - `out_instr_valid` is high exactly when count ≠ 0, and it is purely registered state.
  - A pop happens when `out_instr_valid` and `in_instr_ready` are both high.
  - A push and a pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.
- **Redirect.** When `in_redirect`=1 it has priority over all other activity:
  - count and the pointers are cleared; any push or pop that cycle is discarded.
  - `pc` is loaded with {`in_redirect_pc`[63:2], 2'b00}.
  - `state` goes to StIssue.
  - A hit that arrives in StCheck during that cycle is dropped.
  - `out_icache_req` is not masked combinationally. A request issued in the redirect cycle produces a response that is ignored, because the next state is StIssue.
- **Reset** (asynchronous, any time, including mid-miss): `pc`=RESET_PC, count=0, pointers=0, `state`=StIssue.
- **Outputs during reset:** `out_icache_req`=0, `out_icache_addr`=RESET_PC, `out_instr_valid`=0, `out_instr`=0, `out_instr_pc`=0 (the FIFO storage is also cleared).

## Timing
- Request/response latency is 1 cycle: a request driven in cycle N is answered, if it hits, in cycle N+1.
- Peak throughput on hits is 1 instruction per 2 cycles.
- An instruction pushed at the end of cycle N appears on `out_instr_valid` in cycle N+1.
- Redirect asserted in cycle R, with the target hitting in the cache:
  - cycle R+1: request issued;
  - cycle R+2: hit;
  - cycle R+3: `out_instr_valid`=1.
- `out_instr_valid` falls in cycle R+1 after a redirect in cycle R.
- Miss penalty is the cache fill time plus at most 2 cycles of re-issue alignment.
- There is no combinational path from `in_instr_ready` or `in_redirect` to any output.

## Configuration
- `SNOW64_INSTR_FETCH_PERF_COUNTERS_EN`
  - **Defined:** adds `out_perf_fetched` (output, 32) and `out_perf_reissues` (output, 32).
    - `out_perf_fetched` counts pushes that were not discarded.
    - `out_perf_reissues` counts StCheck cycles with `in_icache_valid`=0.
    - Both reset to 0, wrap at 2^32, and are not cleared by redirect.
  - **Undefined:** these ports and their counters do not exist; all other behaviour is identical.

## Test plan
1. **Reset, hit stream.** Release reset with RESET_PC=0 and a cache model that always hits, returning instr = addr ^ 32'hA5A5A5A5, with `in_instr_ready`=1. Required: requests at addrs 0, 4, 8 in every other cycle, and `out_instr_pc` sequence 0, 4, 8 carrying the matching instrs.
2. **Miss then fill.** The cache misses addr 0x40 for 6 cycles, then hits. Required: `out_icache_req` is re-issued with addr 0x40 every 2 cycles; exactly one push of pc 0x40; no duplicate.
3. **Backpressure full.** FIFO_DEPTH=4, `in_instr_ready`=0, all hits. Required: count saturates at 4, `out_icache_req` stays 0 afterwards, and `pc`=0x10. On raising ready, the entries drain in order with pcs 0x0–0xC.
4. **Redirect during a hit.** Assert `in_redirect` with `in_redirect_pc`=0x1003 in a StCheck cycle that has `in_icache_valid`=1, while the FIFO holds 3 entries. Required: `out_instr_valid`=0 in the next cycle; the next request addr is 0x1000; the dropped instruction is never output.
5. **Simultaneous push and pop at full-1.** With count=3, push and pop in the same cycle. Required: count stays 3, order is preserved, no overflow.
6. **Async reset mid-miss.** Pull `rst_n` low between clock edges while a miss is outstanding. Required: outputs take their reset values immediately; after release, fetch restarts at RESET_PC. With the macro defined, both counters read 0.
